// File: rtl/xbus_tag_receiver.sv
// xbus_tag_receiver
//   Receiving end of the X-bus global-buffer-to-PE path for one PE column.
//   Watches the shared G2B bus and accepts words tagged for this column
//   (or broadcast), then queues them in a first-word-fall-through FIFO.
//   The queued words are presented to the PE with a valid/ready handshake.
//   Unmatched words are consumed and discarded, so every column on the bus
//   stalls in lockstep on bus_ready alone.
//   The PE result psum is returned to the B2G bus through a one-entry skid
//   register.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   cfg_we, cfg_id            program the column ID
//   bus_valid/bus_ready       G2B handshake
//   bus_tag, bus_bcast        destination column / broadcast flag
//   *_data_G2B                incoming ifmap, fltr and psum words
//   pe_valid/pe_ready         FIFO head handshake toward the PE
//   pe_ifmap/pe_fltr/pe_psum  FIFO head; all zero when the FIFO is empty
//   pe_psum_valid/_ready/_res PE result handshake
//   psum_data_B2G, psum_B2G_valid/_ready   result handshake toward the bus
//   acc_cnt, drop_cnt         status counters of matched and dropped words
//
// Optional feature macro: XBUS_RX_STATUS_CNT_EN
//   When defined, acc_cnt and drop_cnt are saturating 16-bit counters.
//   When it is undefined, both ports are tied to zero.

module xbus_tag_receiver #(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned NUM_COL    = 4,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned IDW        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int unsigned PW         = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_we,
  input  logic [IDW-1:0]        cfg_id,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  input  logic [IDW-1:0]        bus_tag,
  input  logic                  bus_bcast,
  input  logic [DATA_WIDTH-1:0] ifmap_data_G2B,
  input  logic [DATA_WIDTH-1:0] fltr_data_G2B,
  input  logic [PW-1:0]         psum_data_G2B,
  output logic                  pe_valid,
  input  logic                  pe_ready,
  output logic [DATA_WIDTH-1:0] pe_ifmap,
  output logic [DATA_WIDTH-1:0] pe_fltr,
  output logic [PW-1:0]         pe_psum,
  input  logic                  pe_psum_valid,
  output logic                  pe_psum_ready,
  input  logic [PW-1:0]         pe_psum_res,
  output logic [PW-1:0]         psum_data_B2G,
  output logic                  psum_B2G_valid,
  input  logic                  psum_B2G_ready,
  output logic [15:0]           acc_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = PTRW + 1;

  // One queued bus word
  typedef struct packed {
    logic [DATA_WIDTH-1:0] ifmap;
    logic [DATA_WIDTH-1:0] fltr;
    logic [PW-1:0]         psum;
  } entry_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [IDW-1:0]  my_id_q,   my_id_d;
  logic [PTRW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNTW-1:0] count_q,   count_d;
  logic            ret_full_q, ret_full_d;
  logic [PW-1:0]   ret_data_q, ret_data_d;
  entry_t          mem_q [FIFO_DEPTH];

  logic   match;
  logic   push;
  logic   pop;
  logic   ret_load;
  entry_t wr_entry;
  entry_t head;

  // ---------------------------------------------------------------------
  // Bus side: ready depends only on occupancy so all columns stall together
  // ---------------------------------------------------------------------
  assign bus_ready = (count_q != CNTW'(FIFO_DEPTH));
  assign match     = bus_bcast || (bus_tag == my_id_q);
  assign push      = bus_valid && bus_ready && match;

  assign wr_entry.ifmap = ifmap_data_G2B;
  assign wr_entry.fltr  = fltr_data_G2B;
  assign wr_entry.psum  = psum_data_G2B;

  // ---------------------------------------------------------------------
  // PE side: first-word-fall-through head, zeroed when empty
  // ---------------------------------------------------------------------
  assign pe_valid = (count_q != '0);
  assign pop      = pe_valid && pe_ready;

  always_comb begin
    head = '0;
    if (pe_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign pe_ifmap = head.ifmap;
  assign pe_fltr  = head.fltr;
  assign pe_psum  = head.psum;

  // ---------------------------------------------------------------------
  // Next-state: ID register, FIFO pointers and occupancy
  // ---------------------------------------------------------------------
  always_comb begin
    my_id_d  = my_id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (cfg_we) begin
      my_id_d = cfg_id;
    end
    // Depth is a power of two, so pointers wrap by natural overflow
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNTW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Return path: one-entry skid register toward the B2G bus
  // ---------------------------------------------------------------------
  assign pe_psum_ready  = !ret_full_q || psum_B2G_ready;
  assign ret_load       = pe_psum_valid && pe_psum_ready;
  assign psum_B2G_valid = ret_full_q;
  assign psum_data_B2G  = ret_data_q;

  always_comb begin
    ret_full_d = ret_full_q;
    ret_data_d = ret_data_q;
    if (ret_load) begin
      ret_full_d = 1'b1;
      ret_data_d = pe_psum_res;
    end else if (ret_full_q && psum_B2G_ready) begin
      ret_full_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      my_id_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ret_full_q <= 1'b0;
      ret_data_q <= '0;
    end else begin
      my_id_q    <= my_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ret_full_q <= ret_full_d;
      ret_data_q <= ret_data_d;
    end
  end

  // FIFO storage; contents are never visible while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------
  // Status counters
  // ---------------------------------------------------------------------
`ifdef XBUS_RX_STATUS_CNT_EN
  logic        drop;
  logic [15:0] acc_cnt_q,  acc_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop = bus_valid && bus_ready && !match;

  // Saturating increments
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push && (acc_cnt_q != 16'hFFFF)) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
    end
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign acc_cnt  = acc_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign acc_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_xbus_tag_receiver.sv
// Directed self-checking bench for xbus_tag_receiver (default parameters).
// Counter expectations follow XBUS_RX_STATUS_CNT_EN: live counts when it is
// defined, zero otherwise.

module tb_xbus_tag_receiver;

  localparam int unsigned DW  = 16;
  localparam int unsigned IDW = 2;
  localparam int unsigned PW  = 32;
`ifdef XBUS_RX_STATUS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic           cfg_we;
  logic [IDW-1:0] cfg_id;
  logic           bus_valid;
  logic           bus_ready;
  logic [IDW-1:0] bus_tag;
  logic           bus_bcast;
  logic [DW-1:0]  ifmap_data_G2B;
  logic [DW-1:0]  fltr_data_G2B;
  logic [PW-1:0]  psum_data_G2B;
  logic           pe_valid;
  logic           pe_ready;
  logic [DW-1:0]  pe_ifmap;
  logic [DW-1:0]  pe_fltr;
  logic [PW-1:0]  pe_psum;
  logic           pe_psum_valid;
  logic           pe_psum_ready;
  logic [PW-1:0]  pe_psum_res;
  logic [PW-1:0]  psum_data_B2G;
  logic           psum_B2G_valid;
  logic           psum_B2G_ready;
  logic [15:0]    acc_cnt;
  logic [15:0]    drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  xbus_tag_receiver dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_we         (cfg_we),
    .cfg_id         (cfg_id),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_tag        (bus_tag),
    .bus_bcast      (bus_bcast),
    .ifmap_data_G2B (ifmap_data_G2B),
    .fltr_data_G2B  (fltr_data_G2B),
    .psum_data_G2B  (psum_data_G2B),
    .pe_valid       (pe_valid),
    .pe_ready       (pe_ready),
    .pe_ifmap       (pe_ifmap),
    .pe_fltr        (pe_fltr),
    .pe_psum        (pe_psum),
    .pe_psum_valid  (pe_psum_valid),
    .pe_psum_ready  (pe_psum_ready),
    .pe_psum_res    (pe_psum_res),
    .psum_data_B2G  (psum_data_B2G),
    .psum_B2G_valid (psum_B2G_valid),
    .psum_B2G_ready (psum_B2G_ready),
    .acc_cnt        (acc_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] cnt_exp(input int n);
    return CNT_EN ? 64'(n) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word pattern derived from the ifmap value
  task automatic set_word(input logic [DW-1:0] v);
    ifmap_data_G2B = v;
    fltr_data_G2B  = v ^ 16'hFFFF;
    psum_data_G2B  = {16'hC0DE, v};
  endtask

  task automatic send(input logic [IDW-1:0] tag, input logic [DW-1:0] v);
    bus_valid = 1'b1;
    bus_tag   = tag;
    set_word(v);
    tick();
    bus_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] v);
    check({tag, "_valid"}, 64'(pe_valid), 64'd1);
    check({tag, "_ifmap"}, 64'(pe_ifmap), 64'(v));
    check({tag, "_fltr"},  64'(pe_fltr),  64'(v ^ 16'hFFFF));
    pe_ready = 1'b1;
    tick();
    pe_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; cfg_we = 1'b0; cfg_id = '0; bus_valid = 1'b0; bus_tag = '0;
    bus_bcast = 1'b0; ifmap_data_G2B = '0; fltr_data_G2B = '0; psum_data_G2B = '0;
    pe_ready = 1'b0; pe_psum_valid = 1'b0; pe_psum_res = '0; psum_B2G_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    check("rst_pe_valid",   64'(pe_valid), 64'd0);
    check("rst_pe_ifmap",   64'(pe_ifmap), 64'd0);
    check("rst_pe_psum",    64'(pe_psum), 64'd0);
    check("rst_bus_ready",  64'(bus_ready), 64'd1);
    check("rst_b2g_valid",  64'(psum_B2G_valid), 64'd0);
    check("rst_b2g_data",   64'(psum_data_B2G), 64'd0);
    check("rst_psum_ready", 64'(pe_psum_ready), 64'd1);
    check("rst_acc",        64'(acc_cnt), 64'd0);
    check("rst_drop",       64'(drop_cnt), 64'd0);

    // Program ID=2; a tag-2 word in the same cycle is compared to old ID 0
    cfg_we = 1'b1; cfg_id = 2'd2;
    bus_valid = 1'b1; bus_tag = 2'd2; set_word(16'h00EE);
    tick();
    cfg_we = 1'b0; bus_valid = 1'b0;
    check("old_id_dropped", 64'(pe_valid), 64'd0);
    check("old_id_drop_cnt", 64'(drop_cnt), cnt_exp(1));

    // Single matched word, visible the cycle after acceptance
    bus_valid = 1'b1; bus_tag = 2'd2;
    ifmap_data_G2B = 16'h0011; fltr_data_G2B = 16'h0022; psum_data_G2B = 32'h0000_0033;
    tick();
    bus_valid = 1'b0;
    check("first_valid", 64'(pe_valid), 64'd1);
    check("first_ifmap", 64'(pe_ifmap), 64'h11);
    check("first_fltr",  64'(pe_fltr),  64'h22);
    check("first_psum",  64'(pe_psum),  64'h33);
    check("first_acc",   64'(acc_cnt), cnt_exp(1));
    pe_ready = 1'b1;
    tick();
    pe_ready = 1'b0;
    check("first_popped", 64'(pe_valid), 64'd0);

    // Tag filtering: only tag-2 words are queued
    send(2'd1, 16'h0100); check("filt_ready0", 64'(bus_ready), 64'd1);
    send(2'd2, 16'h0101); check("filt_ready1", 64'(bus_ready), 64'd1);
    send(2'd3, 16'h0102); check("filt_ready2", 64'(bus_ready), 64'd1);
    send(2'd2, 16'h0103); check("filt_ready3", 64'(bus_ready), 64'd1);
    check("filt_drop", 64'(drop_cnt), cnt_exp(3));
    check("filt_acc",  64'(acc_cnt),  cnt_exp(3));
    check("filt_psum", 64'(pe_psum),  64'h0000_C0DE_0101);
    pop_check("filt_w1", 16'h0101);
    pop_check("filt_w3", 16'h0103);
    check("filt_empty", 64'(pe_valid), 64'd0);

    // Fill to full, fifth word stalls on the bus
    for (int k = 0; k < 5; k++) begin
      bus_valid = 1'b1; bus_tag = 2'd2;
      set_word(16'h0200 + 16'(k));
      if (k < 4) begin
        check("fill_ready", 64'(bus_ready), 64'd1);
        tick();
      end
    end
    check("full_ready", 64'(bus_ready), 64'd0);
    tick();
    check("full_stall_ready", 64'(bus_ready), 64'd0);
    check("full_stall_head",  64'(pe_ifmap),  64'h200);
    pe_ready = 1'b1;
    tick();
    pe_ready = 1'b0;
    check("after_pop_ready", 64'(bus_ready), 64'd1);
    check("after_pop_head",  64'(pe_ifmap),  64'h201);
    tick();
    bus_valid = 1'b0;
    check("refull_ready", 64'(bus_ready), 64'd0);
    check("refull_acc",   64'(acc_cnt), cnt_exp(8));
    pop_check("order_w1", 16'h0201);
    pop_check("order_w2", 16'h0202);
    pop_check("order_w3", 16'h0203);
    pop_check("order_w4", 16'h0204);
    check("order_empty", 64'(pe_valid), 64'd0);
    check("empty_zero",  64'(pe_ifmap), 64'd0);

    // Push and pop in the same cycle at count 2
    send(2'd2, 16'h0301);
    send(2'd2, 16'h0302);
    bus_valid = 1'b1; bus_tag = 2'd2; set_word(16'h0303);
    pe_ready = 1'b1;
    tick();
    bus_valid = 1'b0; pe_ready = 1'b0;
    pop_check("pp_w2", 16'h0302);
    pop_check("pp_w3", 16'h0303);
    check("pp_empty", 64'(pe_valid), 64'd0);
    check("pp_acc",   64'(acc_cnt), cnt_exp(11));

    // Bcast word with a foreign tag is accepted
    bus_bcast = 1'b1;
    send(2'd0, 16'h0350);
    bus_bcast = 1'b0;
    pop_check("bcast", 16'h0350);

    // Return path: hold under back-pressure, then back-to-back
    pe_psum_valid = 1'b1; pe_psum_res = 32'hDEAD_BEEF;
    tick();
    pe_psum_valid = 1'b0;
    check("ret_valid",      64'(psum_B2G_valid), 64'd1);
    check("ret_data",       64'(psum_data_B2G),  64'hDEAD_BEEF);
    check("ret_full_ready", 64'(pe_psum_ready),  64'd0);
    tick();
    check("ret_hold_valid", 64'(psum_B2G_valid), 64'd1);
    check("ret_hold_data",  64'(psum_data_B2G),  64'hDEAD_BEEF);
    psum_B2G_ready = 1'b1; pe_psum_valid = 1'b1; pe_psum_res = 32'h0000_1234;
    #1;
    check("ret_pass_ready", 64'(pe_psum_ready), 64'd1);
    tick();
    pe_psum_valid = 1'b0;
    check("ret_b2b_valid", 64'(psum_B2G_valid), 64'd1);
    check("ret_b2b_data",  64'(psum_data_B2G),  64'h1234);
    tick();
    check("ret_drained", 64'(psum_B2G_valid), 64'd0);
    psum_B2G_ready = 1'b0;

    // Reset mid-operation with queued and pending return data
    send(2'd2, 16'h0501);
    send(2'd2, 16'h0502);
    send(2'd2, 16'h0503);
    pe_psum_valid = 1'b1; pe_psum_res = 32'h5555_AAAA;
    tick();
    pe_psum_valid = 1'b0;
    check("pre_rst_ret", 64'(psum_B2G_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_pe_valid", 64'(pe_valid), 64'd0);
    check("mid_rst_b2g",      64'(psum_B2G_valid), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_ready",  64'(bus_ready), 64'd1);
    check("post_rst_valid",  64'(pe_valid),  64'd0);
    check("post_rst_data",   64'(psum_data_B2G), 64'd0);
    check("post_rst_acc",    64'(acc_cnt),  64'd0);
    check("post_rst_drop",   64'(drop_cnt), 64'd0);

    // ID register back to 0 after reset
    send(2'd0, 16'h0600);
    check("id0_valid", 64'(pe_valid), 64'd1);
    check("id0_ifmap", 64'(pe_ifmap), 64'h600);
    check("id0_acc",   64'(acc_cnt),  cnt_exp(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
